// File: rtl/text_pkg.sv
// text_pkg: shared types and constants for the text-mode tile generator.
//   GLYPH_W/GLYPH_H : glyph cell size in pixels (before scaling)
//   CHAR_SPACE      : code written into every cell by the clear sweep
//   ATTR_DEFAULT    : attribute written by the clear sweep {blink=0, fg=green}
//   RGB_*           : 3-bit colour constants {r,g,b}
//   cell_t          : one character-buffer word {chr, attr}
//   fsm_t           : buffer-clear FSM states
//   font_pixel()    : picks one pixel out of a font row, MSB = leftmost
package text_pkg;

  localparam int GLYPH_W = 8;
  localparam int GLYPH_H = 16;

  localparam logic [6:0] CHAR_SPACE   = 7'h20;
  localparam logic [3:0] ATTR_DEFAULT = 4'b0010;

  localparam logic [2:0] RGB_BLACK   = 3'b000;
  localparam logic [2:0] RGB_BLUE    = 3'b001;
  localparam logic [2:0] RGB_GREEN   = 3'b010;
  localparam logic [2:0] RGB_MAGENTA = 3'b101;
  localparam logic [2:0] RGB_WHITE   = 3'b111;

  // attr = {blink, fg_rgb[2:0]}
  typedef struct packed {
    logic [6:0] chr;
    logic [3:0] attr;
  } cell_t;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } fsm_t;

  function automatic logic font_pixel(input logic [7:0] row_bits, input logic [2:0] bit_idx);
    return row_bits[3'd7 - bit_idx];
  endfunction

endpackage

// File: rtl/text_tile_gen_if.sv
// text_tile_gen_if: host/video-side bundle of the text tile generator.
//   video inputs  : video_on, pixel_x, pixel_y, frame_tick
//   write port    : wr_en, wr_col, wr_row, wr_char, wr_attr -> wr_ready
//   cursor        : cursor_en, cursor_col, cursor_row
//   video outputs : text_on, rgb_text (registered, 3 clocks after the pixel)
//   debug         : state (buffer-clear FSM state)
//
// Write handshake: a cell write happens on a rising clk edge where wr_en and
// wr_ready are both 1. There is no back-pressure queue: a write presented
// while wr_ready is 0, or with wr_col/wr_row outside the buffer, is dropped
// and never retried. wr_ready is 0 for the whole post-reset clear sweep and
// 1 afterwards.
interface text_tile_gen_if;
  import text_pkg::*;

  logic       video_on;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       frame_tick;

  logic       wr_en;
  logic [6:0] wr_col;
  logic [4:0] wr_row;
  logic [6:0] wr_char;
  logic [3:0] wr_attr;
  logic       wr_ready;

  logic       cursor_en;
  logic [6:0] cursor_col;
  logic [4:0] cursor_row;

  logic       text_on;
  logic [2:0] rgb_text;
  fsm_t       state;

  modport master (
    output video_on, pixel_x, pixel_y, frame_tick,
    output wr_en, wr_col, wr_row, wr_char, wr_attr,
    output cursor_en, cursor_col, cursor_row,
    input  wr_ready, text_on, rgb_text, state
  );

  modport slave (
    input  video_on, pixel_x, pixel_y, frame_tick,
    input  wr_en, wr_col, wr_row, wr_char, wr_attr,
    input  cursor_en, cursor_col, cursor_row,
    output wr_ready, text_on, rgb_text, state
  );

endinterface

// File: rtl/ROM_font.sv
// ROM_font: 2048x8 glyph ROM, 128 codes x 16 rows, registered output
// (1-cycle latency). Bit 7 of a row is the leftmost pixel.
//   clk  : clock
//   addr : {char_code[6:0], glyph_row[3:0]}
//   data : font row, valid the cycle after addr
// This image carries the glyphs the overlay currently needs: space is
// blank, 'A' is the standard 8x16 shape, and every other code shows a
// hollow box so an unexpected code is visible on screen.
module ROM_font (
  input  logic        clk,
  input  logic [10:0] addr,
  output logic [7:0]  data
);

  logic [7:0] row_bits;

  always_comb begin
    row_bits = 8'h00;
    if (addr[10:4] == 7'h41) begin
      case (addr[3:0])
        4'd2:                      row_bits = 8'h10;
        4'd3:                      row_bits = 8'h38;
        4'd4:                      row_bits = 8'h6C;
        4'd5, 4'd6:                row_bits = 8'hC6;
        4'd7:                      row_bits = 8'hFE;
        4'd8, 4'd9, 4'd10, 4'd11:  row_bits = 8'hC6;
        default:                   row_bits = 8'h00;
      endcase
    end else if (addr[10:4] != 7'h20) begin
      row_bits = (addr[3:0] == 4'd0 || addr[3:0] == 4'hF) ? 8'hFF : 8'h81;
    end
  end

  always_ff @(posedge clk) begin
    data <= row_bits;
  end

endmodule

// File: rtl/char_ram.sv
// char_ram: simple dual-port character buffer, one write port and one
// synchronous read port, read-first (a same-cycle write to the read cell
// returns the old word).
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write word
//   raddr : read address
//   rdata : read word, valid the cycle after raddr
module char_ram #(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7,
  parameter int W      = 11
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [W-1:0]      wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [W-1:0]      rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/text_tile_gen.sv
// text_tile_gen: text-mode overlay for the VGA path. A COLSxROWS character
// buffer with per-cell {blink, fg} attribute is rendered with 8x16 glyphs
// from ROM_font, scaled by 2^SCALE_LOG2, at (ORIGIN_X, ORIGIN_Y). A blinking
// cursor inverts its cell. Output is a fixed 3-clock pipeline behind
// pixel_x/pixel_y/video_on. After reset the buffer is swept to spaces,
// one cell per clock, before host writes are accepted.
//   clk   : pixel clock
//   reset : synchronous, active-high
//   bus   : text_tile_gen_if.slave (video, write port, cursor, outputs)
module text_tile_gen
  import text_pkg::*;
#(
  parameter int COLS         = 32,
  parameter int ROWS         = 4,
  parameter int ORIGIN_X     = 0,
  parameter int ORIGIN_Y     = 0,
  parameter int SCALE_LOG2   = 0,
  parameter int BLINK_FRAMES = 30
) (
  input logic            clk,
  input logic            reset,
  text_tile_gen_if.slave bus
);

  localparam int DEPTH  = COLS * ROWS;
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BCW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam int unsigned WIN_W = (COLS * GLYPH_W) << SCALE_LOG2;
  localparam int unsigned WIN_H = (ROWS * GLYPH_H) << SCALE_LOG2;

  localparam logic [10:0]       ORG_X      = 11'(ORIGIN_X);
  localparam logic [10:0]       ORG_Y      = 11'(ORIGIN_Y);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [BCW-1:0]    LAST_BLINK = BCW'(BLINK_FRAMES - 1);

  // ---------------- clear FSM ----------------
  fsm_t              state;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_ready_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= CLEAR;
      clr_addr   <= '0;
      wr_ready_q <= 1'b0;
    end else if (state == CLEAR) begin
      if (clr_addr == LAST_ADDR) begin
        state      <= IDLE;
        clr_addr   <= '0;
        wr_ready_q <= 1'b1;
      end else begin
        clr_addr <= clr_addr + 1'b1;
      end
    end
  end

  // ---------------- write port mux ----------------
  logic              host_hit;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  cell_t             wdata;

  always_comb begin
    host_hit = bus.wr_en && wr_ready_q && (state == IDLE)
               && (32'(bus.wr_col) < COLS) && (32'(bus.wr_row) < ROWS);
    we    = 1'b0;
    waddr = clr_addr;
    wdata = '{chr: CHAR_SPACE, attr: ATTR_DEFAULT};
    if (!reset) begin
      if (state == CLEAR) begin
        we = 1'b1;
      end else if (host_hit) begin
        we    = 1'b1;
        waddr = ADDR_W'(32'(bus.wr_row) * COLS + 32'(bus.wr_col));
        wdata = '{chr: bus.wr_char, attr: bus.wr_attr};
      end
    end
  end

  // ---------------- blink ----------------
  logic [BCW-1:0] blink_cnt;
  logic           blink_phase;

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (bus.frame_tick) begin
      if (blink_cnt == LAST_BLINK) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // ---------------- stage 0: tile math ----------------
  // dx/dy wrap when the pixel is left of/above the origin, so the
  // origin compare is done on the raw coordinate first.
  logic [10:0]       dx, dy;
  logic [10:0]       col0, row0;
  logic              in_win0;
  logic              cur0;
  logic [ADDR_W-1:0] raddr;

  always_comb begin
    dx      = {1'b0, bus.pixel_x} - ORG_X;
    dy      = {1'b0, bus.pixel_y} - ORG_Y;
    in_win0 = ({1'b0, bus.pixel_x} >= ORG_X) && (32'(dx) < WIN_W)
              && ({1'b0, bus.pixel_y} >= ORG_Y) && (32'(dy) < WIN_H);
    col0    = dx >> (3 + SCALE_LOG2);
    row0    = dy >> (4 + SCALE_LOG2);
    cur0    = bus.cursor_en && (col0 == 11'(bus.cursor_col)) && (row0 == 11'(bus.cursor_row));
    raddr   = in_win0 ? ADDR_W'(32'(row0) * COLS + 32'(col0)) : '0;
  end

  cell_t rd_cell;

  char_ram #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .W     ($bits(cell_t))
  ) u_char_ram (
    .clk  (clk),
    .we   (we),
    .waddr(waddr),
    .wdata(wdata),
    .raddr(raddr),
    .rdata(rd_cell)
  );

  // ---------------- stage 1/2 side-band ----------------
  logic       s1_vid, s1_win, s1_cur;
  logic [2:0] s1_bit;
  logic [3:0] s1_grow;
  logic       s2_vid, s2_win, s2_cur;
  logic [2:0] s2_bit;
  logic [3:0] s2_attr;
  logic [7:0] font_row;

  ROM_font u_font (
    .clk (clk),
    .addr({rd_cell.chr, s1_grow}),
    .data(font_row)
  );

  // Cursor inversion happens after the attribute blink so a cursor on a
  // blinking cell still shows.
  logic px2;
  always_comb begin
    px2 = font_pixel(font_row, s2_bit) && !(s2_attr[3] && blink_phase);
    if (s2_cur && blink_phase) begin
      px2 = !px2;
    end
  end

  logic       text_on_q;
  logic [2:0] rgb_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vid    <= 1'b0;
      s1_win    <= 1'b0;
      s1_cur    <= 1'b0;
      s1_bit    <= '0;
      s1_grow   <= '0;
      s2_vid    <= 1'b0;
      s2_win    <= 1'b0;
      s2_cur    <= 1'b0;
      s2_bit    <= '0;
      s2_attr   <= '0;
      text_on_q <= 1'b0;
      rgb_q     <= RGB_BLACK;
    end else begin
      s1_vid  <= bus.video_on;
      s1_win  <= in_win0;
      s1_cur  <= cur0;
      s1_bit  <= 3'(dx >> SCALE_LOG2);
      s1_grow <= 4'(dy >> SCALE_LOG2);
      s2_vid  <= s1_vid;
      s2_win  <= s1_win;
      s2_cur  <= s1_cur;
      s2_bit  <= s1_bit;
      s2_attr <= rd_cell.attr;
      if (!s2_vid || !s2_win || state == CLEAR) begin
        text_on_q <= 1'b0;
        rgb_q     <= RGB_BLACK;
      end else begin
        text_on_q <= px2;
        rgb_q     <= px2 ? s2_attr[2:0] : RGB_BLACK;
      end
    end
  end

  assign bus.wr_ready = wr_ready_q;
  assign bus.text_on  = text_on_q;
  assign bus.rgb_text = rgb_q;
  assign bus.state    = state;

endmodule

// File: tb/tb_text_tile_gen.sv
// Directed bench for text_tile_gen. Two instances: dut_a with the default
// 32x4 window at the origin, dut_b with a 4x2 window at x=64 scaled x2.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_text_tile_gen;
  import text_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  text_tile_gen_if if_a ();
  text_tile_gen_if if_b ();

  text_tile_gen #(
    .COLS(32), .ROWS(4), .ORIGIN_X(0), .ORIGIN_Y(0), .SCALE_LOG2(0), .BLINK_FRAMES(30)
  ) dut_a (
    .clk(clk), .reset(reset), .bus(if_a)
  );

  text_tile_gen #(
    .COLS(4), .ROWS(2), .ORIGIN_X(64), .ORIGIN_Y(0), .SCALE_LOG2(1), .BLINK_FRAMES(30)
  ) dut_b (
    .clk(clk), .reset(reset), .bus(if_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference rows of the 'A' glyph, bit 7 = leftmost pixel.
  logic [7:0] glyph_a [16] = '{8'h00, 8'h00, 8'h10, 8'h38, 8'h6C, 8'hC6, 8'hC6, 8'hFE,
                               8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'h00, 8'h00, 8'h00, 8'h00};

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    if_a.video_on = 1'b0; if_a.pixel_x = '0; if_a.pixel_y = '0; if_a.frame_tick = 1'b0;
    if_a.wr_en = 1'b0; if_a.wr_col = '0; if_a.wr_row = '0; if_a.wr_char = '0; if_a.wr_attr = '0;
    if_a.cursor_en = 1'b0; if_a.cursor_col = '0; if_a.cursor_row = '0;
    if_b.video_on = 1'b0; if_b.pixel_x = '0; if_b.pixel_y = '0; if_b.frame_tick = 1'b0;
    if_b.wr_en = 1'b0; if_b.wr_col = '0; if_b.wr_row = '0; if_b.wr_char = '0; if_b.wr_attr = '0;
    if_b.cursor_en = 1'b0; if_b.cursor_col = '0; if_b.cursor_row = '0;
  endtask

  task automatic set_px_a(input int x, input int y, input logic vid);
    if_a.pixel_x  = 10'(x);
    if_a.pixel_y  = 10'(y);
    if_a.video_on = vid;
  endtask

  task automatic probe_a(input int x, input int y, input logic vid, output logic [3:0] obs);
    set_px_a(x, y, vid);
    repeat (3) @(negedge clk);
    obs = {if_a.text_on, if_a.rgb_text};
  endtask

  task automatic probe_b(input int x, input int y, input logic vid, output logic [3:0] obs);
    if_b.pixel_x  = 10'(x);
    if_b.pixel_y  = 10'(y);
    if_b.video_on = vid;
    repeat (3) @(negedge clk);
    obs = {if_b.text_on, if_b.rgb_text};
  endtask

  task automatic write_a(input int col, input int row, input logic [6:0] ch, input logic [3:0] attr);
    if_a.wr_col = 7'(col); if_a.wr_row = 5'(row); if_a.wr_char = ch; if_a.wr_attr = attr;
    if_a.wr_en = 1'b1;
    @(negedge clk);
    if_a.wr_en = 1'b0;
  endtask

  task automatic write_b(input int col, input int row, input logic [6:0] ch, input logic [3:0] attr);
    if_b.wr_col = 7'(col); if_b.wr_row = 5'(row); if_b.wr_char = ch; if_b.wr_attr = attr;
    if_b.wr_en = 1'b1;
    @(negedge clk);
    if_b.wr_en = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      if_a.frame_tick = 1'b1;
      @(negedge clk);
      if_a.frame_tick = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Counts falling edges with wr_ready low, bounded.
  task automatic wait_ready_a(output int cycles);
    cycles = 0;
    while (if_a.wr_ready !== 1'b1 && cycles < 1000) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int cyc;
    logic [3:0] obs;
    int xs [5] = '{0, 3, 255, 100, 16};
    int ys [5] = '{0, 2, 63, 40, 16};
    pulse_reset();
    n_checks++;
    if ({if_a.wr_ready, if_a.text_on, if_a.rgb_text} !== 5'b0)
      $display("FAIL reset_outputs got=%b want=00000", {if_a.wr_ready, if_a.text_on, if_a.rgb_text});
    else n_pass++;
    n_checks++;
    if (if_a.state !== CLEAR) $display("FAIL reset_state got=%0d want=%0d", if_a.state, CLEAR);
    else n_pass++;
    wait_ready_a(cyc);
    n_checks++;
    if (cyc != 128) $display("FAIL clear_length got=%0d want=128", cyc);
    else n_pass++;
    n_checks++;
    if (if_a.state !== IDLE) $display("FAIL state_after_clear got=%0d want=%0d", if_a.state, IDLE);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      probe_a(xs[i], ys[i], 1'b1, obs);
      n_checks++;
      if (obs !== 4'b0000) $display("FAIL cleared_cell x=%0d y=%0d got=%b want=0000", xs[i], ys[i], obs);
      else n_pass++;
    end
  endtask

  task automatic test_glyph();
    logic [3:0] exp_q [$];
    logic [3:0] exp;
    logic [3:0] obs;
    write_a(0, 0, 7'h41, 4'b0010);
    for (int i = 0; i < 131; i++) begin
      if (i < 128) begin
        set_px_a(i % 8, i / 8, 1'b1);
        exp_q.push_back(glyph_a[i / 8][7 - (i % 8)] ? {1'b1, RGB_GREEN} : 4'b0000);
      end else begin
        set_px_a(0, 0, 1'b0);
      end
      if (i >= 3) begin
        exp = exp_q.pop_front();
        obs = {if_a.text_on, if_a.rgb_text};
        n_checks++;
        if (obs !== exp) $display("FAIL glyph_scan x=%0d y=%0d got=%b want=%b", (i - 3) % 8, (i - 3) / 8, obs, exp);
        else n_pass++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_colour();
    logic [3:0] obs;
    int xs [4] = '{43, 43, 43, 40};
    int ys [4] = '{34, 32, 34, 37};
    logic vs [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [3:0] ex [4] = '{4'b1101, 4'b0000, 4'b0000, 4'b1101};
    write_a(5, 2, 7'h41, 4'b0101);
    for (int i = 0; i < 4; i++) begin
      probe_a(xs[i], ys[i], vs[i], obs);
      n_checks++;
      if (obs !== ex[i]) $display("FAIL colour x=%0d y=%0d vid=%0d got=%b want=%b", xs[i], ys[i], vs[i], obs, ex[i]);
      else n_pass++;
    end
  endtask

  task automatic test_blink();
    logic [3:0] obs;
    int steps [5] = '{0, 29, 1, 29, 1};
    logic [3:0] ex [5] = '{4'b1010, 4'b1010, 4'b0000, 4'b0000, 4'b1010};
    write_a(0, 0, 7'h41, 4'b1010);
    for (int i = 0; i < 5; i++) begin
      ticks(steps[i]);
      probe_a(3, 2, 1'b1, obs);
      n_checks++;
      if (obs !== ex[i]) $display("FAIL blink step=%0d got=%b want=%b", i, obs, ex[i]);
      else n_pass++;
      if (i == 2) begin
        // blink_phase=1: a non-blinking cell keeps its glyph
        probe_a(43, 34, 1'b1, obs);
        n_checks++;
        if (obs !== 4'b1101) $display("FAIL blink_other_cell got=%b want=1101", obs);
        else n_pass++;
      end
    end
  endtask

  task automatic test_cursor();
    logic [3:0] obs;
    int xs [6] = '{16, 23, 24, 15, 16, 16};
    int ys [6] = '{16, 31, 16, 16, 15, 16};
    logic vs [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [3:0] ex [6] = '{4'b1010, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    if_a.cursor_en = 1'b1; if_a.cursor_col = 7'd2; if_a.cursor_row = 5'd1;
    probe_a(16, 16, 1'b1, obs);
    n_checks++;
    if (obs !== 4'b0000) $display("FAIL cursor_phase0 got=%b want=0000", obs);
    else n_pass++;
    ticks(30);
    for (int i = 0; i < 6; i++) begin
      probe_a(xs[i], ys[i], vs[i], obs);
      n_checks++;
      if (obs !== ex[i]) $display("FAIL cursor x=%0d y=%0d vid=%0d got=%b want=%b", xs[i], ys[i], vs[i], obs, ex[i]);
      else n_pass++;
    end
    // cursor over a glyph cell inverts it
    if_a.cursor_col = 7'd5; if_a.cursor_row = 5'd2;
    probe_a(43, 34, 1'b1, obs);
    n_checks++;
    if (obs !== 4'b0000) $display("FAIL cursor_invert_lit got=%b want=0000", obs);
    else n_pass++;
    probe_a(40, 32, 1'b1, obs);
    n_checks++;
    if (obs !== 4'b1101) $display("FAIL cursor_invert_unlit got=%b want=1101", obs);
    else n_pass++;
    if_a.cursor_en = 1'b0;
    probe_a(40, 32, 1'b1, obs);
    n_checks++;
    if (obs !== 4'b0000) $display("FAIL cursor_off got=%b want=0000", obs);
    else n_pass++;
  endtask

  task automatic test_scale();
    logic [3:0] obs;
    int xs [8] = '{63, 64, 65, 66, 68, 70, 68, 64};
    int ys [8] = '{10, 10, 10, 11, 10, 4, 4, 4};
    logic [3:0] ex [8] = '{4'b0000, 4'b1010, 4'b1010, 4'b1010, 4'b0000, 4'b1010, 4'b0000, 4'b0000};
    n_checks++;
    if (if_b.wr_ready !== 1'b1) $display("FAIL scale_ready got=%b want=1", if_b.wr_ready);
    else n_pass++;
    write_b(0, 0, 7'h41, 4'b0010);
    for (int i = 0; i < 8; i++) begin
      probe_b(xs[i], ys[i], 1'b1, obs);
      n_checks++;
      if (obs !== ex[i]) $display("FAIL scale x=%0d y=%0d got=%b want=%b", xs[i], ys[i], obs, ex[i]);
      else n_pass++;
    end
  endtask

  task automatic test_drop_and_restart();
    int cyc;
    logic [3:0] obs;
    pulse_reset();
    repeat (5) @(negedge clk);
    write_a(0, 0, 7'h41, 4'b0010);
    wait_ready_a(cyc);
    n_checks++;
    if (cyc != 122) $display("FAIL clear_length_2 got=%0d want=122", cyc);
    else n_pass++;
    probe_a(3, 2, 1'b1, obs);
    n_checks++;
    if (obs !== 4'b0000) $display("FAIL write_during_clear got=%b want=0000", obs);
    else n_pass++;
    write_a(32, 0, 7'h41, 4'b0010);
    write_a(0, 4, 7'h41, 4'b0010);
    probe_a(3, 18, 1'b1, obs);
    n_checks++;
    if (obs !== 4'b0000) $display("FAIL col_out_of_range got=%b want=0000", obs);
    else n_pass++;
    probe_a(3, 2, 1'b1, obs);
    n_checks++;
    if (obs !== 4'b0000) $display("FAIL row_out_of_range got=%b want=0000", obs);
    else n_pass++;
    write_a(1, 0, 7'h41, 4'b0010);
    probe_a(11, 2, 1'b1, obs);
    n_checks++;
    if (obs !== 4'b1010) $display("FAIL valid_write got=%b want=1010", obs);
    else n_pass++;
    // reset mid-operation
    pulse_reset();
    n_checks++;
    if ({if_a.wr_ready, if_a.text_on, if_a.rgb_text, if_a.state} !== {5'b0, CLEAR})
      $display("FAIL midop_reset got=%b want=000000", {if_a.wr_ready, if_a.text_on, if_a.rgb_text, if_a.state});
    else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({if_a.text_on, if_a.rgb_text} !== 4'b0000)
      $display("FAIL blank_during_clear got=%b want=0000", {if_a.text_on, if_a.rgb_text});
    else n_pass++;
    wait_ready_a(cyc);
    n_checks++;
    if (cyc != 125) $display("FAIL clear_length_3 got=%0d want=125", cyc);
    else n_pass++;
    probe_a(11, 2, 1'b1, obs);
    n_checks++;
    if (obs !== 4'b0000) $display("FAIL cleared_after_restart got=%b want=0000", obs);
    else n_pass++;
  endtask

  // ---------------- sequence ----------------
  initial begin
    reset = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_glyph();
    test_colour();
    test_blink();
    test_cursor();
    test_scale();
    test_drop_and_restart();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, checks=%0d passed=%0d", n_checks, n_pass);
    $fatal(1);
  end

endmodule
